// File: rtl/irq_servicer.sv
// Interrupt servicer: programs the enable mask, reads the pending register on irq,
// presents the lowest pending vector and acknowledges it once the consumer takes it.
module irq_servicer #(
  parameter int INTR_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15,
  localparam int IdW       = (INTR_WIDTH > 1) ? $clog2(INTR_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  irq,
  input  logic [INTR_WIDTH-1:0] cfg_enable,
  input  logic                  cfg_load,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [DATA_WIDTH-1:0] bus_write_data,
  input  logic [DATA_WIDTH-1:0] bus_read_data,
  input  logic                  bus_access_complete,
  output logic                  vec_valid,
  output logic [IdW-1:0]        vec_id,
  input  logic                  vec_ready,
  output logic                  spurious,
  output logic                  bus_error,
  output logic [2:0]            dbg_state
);

  localparam int CntW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] AddrEnable  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] AddrAck     = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] AddrPending = ADDR_WIDTH'(8);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_EN, S_WAIT_IRQ, S_RD_PEND, S_DISPATCH, S_WR_ACK, S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [INTR_WIDTH-1:0] shadow_q, shadow_d;
  logic                  load_q, load_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  vec_valid_q, vec_valid_d;
  logic [IdW-1:0]        vec_id_q, vec_id_d;
  logic                  spurious_q, spurious_d;
  logic                  bus_error_q, bus_error_d;

  logic                  in_access;
  logic [INTR_WIDTH-1:0] pend_field;
  logic [IdW-1:0]        pend_sel;
  logic                  unused_rdata;

  assign pend_field   = bus_read_data[INTR_WIDTH-1:0];
  assign unused_rdata = ^bus_read_data;
  assign in_access    = (state_q == S_WR_EN) || (state_q == S_RD_PEND) || (state_q == S_WR_ACK);

  // Strobes and address decode straight from state so they are stable for the whole access.
  assign bus_read       = (state_q == S_RD_PEND);
  assign bus_write      = (state_q == S_WR_EN) || (state_q == S_WR_ACK);
  assign bus_write_data = wdata_q;
  assign vec_valid      = vec_valid_q;
  assign vec_id         = vec_id_q;
  assign spurious       = spurious_q;
  assign bus_error      = bus_error_q;
  assign dbg_state      = state_q;

  always_comb begin
    bus_address = '0;
    case (state_q)
      S_WR_EN:   bus_address = AddrEnable;
      S_RD_PEND: bus_address = AddrPending;
      S_WR_ACK:  bus_address = AddrAck;
      default:   bus_address = '0;
    endcase
  end

  always_comb begin
    pend_sel = '0;
    for (int i = INTR_WIDTH - 1; i >= 0; i--) begin
      if (pend_field[i]) pend_sel = IdW'(i);
    end
  end

  // Vector handshake: vec_valid/vec_id hold until a cycle with vec_valid & vec_ready.
  always_comb begin
    state_d     = state_q;
    shadow_d    = cfg_load ? cfg_enable : shadow_q;
    load_d      = load_q | cfg_load;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    vec_valid_d = vec_valid_q;
    vec_id_d    = vec_id_q;
    spurious_d  = 1'b0;
    bus_error_d = bus_error_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_WR_EN;
        wdata_d = DATA_WIDTH'(shadow_d);
        cnt_d   = '0;
      end
      S_WR_EN: begin
        if (bus_access_complete) begin
          state_d = S_WAIT_IRQ;
          load_d  = cfg_load;
          wdata_d = '0;
        end
      end
      S_WAIT_IRQ: begin
        cnt_d = '0;
        if (load_q || cfg_load) begin
          state_d = S_WR_EN;
          wdata_d = DATA_WIDTH'(shadow_d);
        end else if (irq) begin
          state_d = S_RD_PEND;
        end
      end
      S_RD_PEND: begin
        if (bus_access_complete) begin
          if (pend_field == '0) begin
            spurious_d = 1'b1;
            state_d    = S_WAIT_IRQ;
          end else begin
            vec_valid_d = 1'b1;
            vec_id_d    = pend_sel;
            state_d     = S_DISPATCH;
          end
        end
      end
      S_DISPATCH: begin
        cnt_d = '0;
        if (vec_ready) begin
          vec_valid_d = 1'b0;
          wdata_d     = DATA_WIDTH'(1) << vec_id_q;
          state_d     = S_WR_ACK;
        end
      end
      S_WR_ACK: begin
        if (bus_access_complete) begin
          state_d = S_WAIT_IRQ;
          wdata_d = '0;
        end
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    // A completion always wins over a timeout landing in the same cycle.
    if (in_access) begin
      if (bus_access_complete) begin
        cnt_d = '0;
      end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
        cnt_d       = '0;
        wdata_d     = '0;
        bus_error_d = 1'b1;
        state_d     = S_ERROR;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      load_q      <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      vec_valid_q <= 1'b0;
      vec_id_q    <= '0;
      spurious_q  <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      load_q      <= load_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      vec_valid_q <= vec_valid_d;
      vec_id_q    <= vec_id_d;
      spurious_q  <= spurious_d;
      bus_error_q <= bus_error_d;
    end
  end

endmodule

// File: tb/tb_irq_servicer.sv
// Bench for irq_servicer: directed scenarios, a bus responder, and a monitor that
// pops expected bus/vector/spurious events from a scoreboard queue.
module tb_irq_servicer;

  localparam int IW = 8;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam int EW = 42;
  localparam logic [1:0] K_SPUR = 2'd0, K_WR = 2'd1, K_RD = 2'd2, K_VEC = 2'd3;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd2, ST_ERR = 3'd6;

  logic          clk;
  logic          reset;
  logic          irq;
  logic [IW-1:0] cfg_enable;
  logic          cfg_load;
  logic          bus_read;
  logic          bus_write;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_write_data;
  logic [DW-1:0] bus_read_data;
  logic          bus_access_complete;
  logic          vec_valid;
  logic [2:0]    vec_id;
  logic          vec_ready;
  logic          spurious;
  logic          bus_error;
  logic [2:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            resp_lat = 2;
  bit            resp_hang = 0;
  logic [DW-1:0] resp_rdata = '0;

  irq_servicer #(.INTR_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .irq(irq), .cfg_enable(cfg_enable), .cfg_load(cfg_load),
    .bus_read(bus_read), .bus_write(bus_write), .bus_address(bus_address),
    .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
    .bus_access_complete(bus_access_complete), .vec_valid(vec_valid), .vec_id(vec_id),
    .vec_ready(vec_ready), .spurious(spurious), .bus_error(bus_error), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] mk_ev(input logic [1:0] k, input logic [7:0] a, input logic [31:0] d);
    return {k, a, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic log_ev(input logic [EW-1:0] ev);
    logic [EW-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got 0x%0h, expected none", ev);
    end else begin
      e = exp_q.pop_front();
      if (e === ev) n_pass++;
      else $display("FAIL event_order: got 0x%0h, expected 0x%0h", ev, e);
    end
  endtask

  task automatic wait_sig(input int which, input int max, input string name);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = bus_read;
        1:       hit = vec_valid;
        default: hit = spurious;
      endcase
      if (hit) break;
    end
    chk(name, hit, 1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string name);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (dbg_state == s && !bus_read && !bus_write) begin
        hit = 1'b1;
        break;
      end
    end
    chk(name, hit, 1);
  endtask

  // ---------------- bus responder ----------------
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    bus_access_complete = 1'b0;
    bus_read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_access_complete = 1'b0;
      if (!reset) begin
        acc_cnt = 0;
      end else if ((bus_read || bus_write) && !resp_hang) begin
        acc_cnt++;
        if (acc_cnt == resp_lat) begin
          bus_access_complete = 1'b1;
          bus_read_data = resp_rdata;
          acc_cnt = 0;
        end
      end else begin
        acc_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if ((bus_write || bus_read) && bus_access_complete)
        log_ev(mk_ev(bus_write ? K_WR : K_RD, {3'b000, bus_address},
                     bus_write ? bus_write_data : 32'h0));
      if (vec_valid && vec_ready) log_ev(mk_ev(K_VEC, 8'h00, {29'd0, vec_id}));
      if (spurious) log_ev(mk_ev(K_SPUR, 8'h00, 32'h0));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic stable;
    int   hi;
    int   act;
    reset = 1'b0; irq = 1'b0; cfg_enable = '0; cfg_load = 1'b0; vec_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_strobes", {bus_read, bus_write}, 0);
    chk("rst_addr", bus_address, 0);
    chk("rst_wdata", bus_write_data, 0);
    chk("rst_vec", {vec_valid, vec_id}, 0);
    chk("rst_flags", {spurious, bus_error}, 0);

    // reset release: enable write of zeros, then idle
    exp_q.push_back(mk_ev(K_WR, 8'h00, 32'h0000_0000));
    @(posedge clk); #1 reset = 1'b1;
    wait_state(ST_WAIT, 20, "t1_reach_wait_irq");
    repeat (3) @(negedge clk);
    chk("t1_idle", {bus_read, bus_write, dbg_state}, {2'b00, ST_WAIT});
    chk("t1_queue", exp_q.size(), 0);

    // load with irq high: enable write precedes the pending read
    resp_rdata = 32'h0000_0001;
    vec_ready  = 1'b1;
    exp_q.push_back(mk_ev(K_WR, 8'h00, 32'h0000_00A5));
    exp_q.push_back(mk_ev(K_RD, 8'h08, 32'h0));
    exp_q.push_back(mk_ev(K_VEC, 8'h00, 32'd0));
    exp_q.push_back(mk_ev(K_WR, 8'h04, 32'h0000_0001));
    @(posedge clk); #1;
    cfg_enable = 8'hA5; cfg_load = 1'b1; irq = 1'b1;
    @(posedge clk); #1 cfg_load = 1'b0;
    chk("t2_write_first", {bus_write, bus_read}, 2'b10);
    wait_sig(0, 20, "t2_read_start");
    irq = 1'b0;
    wait_state(ST_WAIT, 30, "t2_back_to_wait");
    vec_ready = 1'b0;
    chk("t2_queue", exp_q.size(), 0);

    // pending 0x28 -> vector 3 held four cycles, ack one-hot 0x08
    resp_rdata = 32'h0000_0028;
    exp_q.push_back(mk_ev(K_RD, 8'h08, 32'h0));
    exp_q.push_back(mk_ev(K_VEC, 8'h00, 32'd3));
    exp_q.push_back(mk_ev(K_WR, 8'h04, 32'h0000_0008));
    @(posedge clk); #1 irq = 1'b1;
    @(negedge clk);
    chk("t3_no_read_yet", bus_read, 0);
    @(negedge clk);
    chk("t3_latency_1cyc", bus_read, 1);
    irq = 1'b0;
    wait_sig(1, 20, "t3_vec_valid");
    chk("t3_vec_id", vec_id, 3);
    stable = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 4) vec_ready = 1'b1;
      @(negedge clk);
      if (!(vec_valid && vec_id == 3'd3)) stable = 1'b0;
    end
    chk("t3_vec_held_4", stable, 1);
    @(posedge clk); #1 vec_ready = 1'b0;
    @(negedge clk);
    chk("t3_vec_dropped", vec_valid, 0);
    wait_state(ST_WAIT, 20, "t3_back_to_wait");
    chk("t3_queue", exp_q.size(), 0);

    // pending 0x00 -> spurious pulse, no ack
    resp_rdata = 32'h0;
    exp_q.push_back(mk_ev(K_RD, 8'h08, 32'h0));
    exp_q.push_back(mk_ev(K_SPUR, 8'h00, 32'h0));
    @(posedge clk); #1 irq = 1'b1;
    wait_sig(0, 20, "t4_read_start");
    irq = 1'b0;
    wait_sig(2, 20, "t4_spurious");
    chk("t4_state_wait", dbg_state, ST_WAIT);
    @(negedge clk);
    chk("t4_pulse_1cyc", spurious, 0);
    repeat (5) @(negedge clk);
    chk("t4_no_ack", {bus_read, bus_write}, 0);
    chk("t4_queue", exp_q.size(), 0);

    // reset during DISPATCH
    resp_rdata = 32'h0000_0080;
    exp_q.push_back(mk_ev(K_RD, 8'h08, 32'h0));
    @(posedge clk); #1 irq = 1'b1;
    wait_sig(0, 20, "t6_read_start");
    irq = 1'b0;
    wait_sig(1, 20, "t6_vec_valid");
    chk("t6_vec_id", vec_id, 7);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    chk("t6_async_vec_valid", vec_valid, 0);
    chk("t6_async_state", dbg_state, ST_IDLE);
    chk("t6_queue", exp_q.size(), 0);
    exp_q.push_back(mk_ev(K_WR, 8'h00, 32'h0));
    @(posedge clk); #1 reset = 1'b1;
    wait_state(ST_WAIT, 20, "t6_restart");
    chk("t6_restart_queue", exp_q.size(), 0);

    // responder hangs on the pending read -> timeout, sticky error
    resp_hang = 1'b1;
    @(posedge clk); #1 irq = 1'b1;
    wait_sig(0, 20, "t5_read_start");
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_read) hi++;
      else break;
    end
    chk("t5_strobe_cycles", hi, TO);
    chk("t5_error_state", {bus_error, dbg_state}, {1'b1, ST_ERR});
    @(posedge clk); #1 cfg_enable = 8'h3C; cfg_load = 1'b1;
    @(posedge clk); #1 cfg_load = 1'b0; vec_ready = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_read || bus_write || vec_valid) act++;
    end
    chk("t5_no_activity", act, 0);
    chk("t5_error_sticky", {bus_error, dbg_state}, {1'b1, ST_ERR});
    irq = 1'b0; vec_ready = 1'b0; resp_hang = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_reset_clears_error", bus_error, 0);
    exp_q.push_back(mk_ev(K_WR, 8'h00, 32'h0));
    @(posedge clk); #1 reset = 1'b1;
    wait_state(ST_WAIT, 20, "t5_restart");

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_servicer.md
IRQ_SERVICER -- requirements
Module: irq_servicer

Interface
REQ-001 Parameter INTR_WIDTH, default 8: number of interrupt lines serviced.
REQ-002 Parameter ADDR_WIDTH, default 5: register bus address width.
REQ-003 Parameter DATA_WIDTH, default 32: register bus data width; SHALL be >= INTR_WIDTH.
REQ-004 Parameter TIMEOUT, default 15: maximum wait, in cycles, for bus_access_complete on one access.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 irq  input  1  level interrupt request from the interrupt controller.
REQ-008 cfg_enable  input  INTR_WIDTH  enable mask to be programmed.
REQ-009 cfg_load  input  1  one-cycle request to program cfg_enable.
REQ-010 bus_read  output  1  read strobe, held until the access completes.
REQ-011 bus_write  output  1  write strobe, held until the access completes.
REQ-012 bus_address  output  ADDR_WIDTH  byte address of the access.
REQ-013 bus_write_data  output  DATA_WIDTH  write data.
REQ-014 bus_read_data  input  DATA_WIDTH  read data, valid in the cycle bus_access_complete=1.
REQ-015 bus_access_complete  input  1  access-done pulse from the responder.
REQ-016 vec_valid  output  1  a serviced interrupt vector is presented.
REQ-017 vec_id  output  $clog2(INTR_WIDTH)  index of the presented interrupt.
REQ-018 vec_ready  input  1  consumer accepts the vector.
REQ-019 spurious  output  1  one-cycle pulse: irq was seen with no pending bit set.
REQ-020 bus_error  output  1  sticky: an access timed out.

Function
REQ-021 Register map (bits [ADDR_WIDTH-1:2]): 0=enable (0x00), 1=ack (0x04), 2=pending (0x08), 3=status (0x0C); unused write-data bits SHALL be 0.
REQ-022 FSM states: IDLE, WR_EN, WAIT_IRQ, RD_PEND, DISPATCH, WR_ACK, ERROR.
REQ-023 IDLE -> WR_EN on the first cycle after reset release; the FSM SHALL write the mask captured at reset (all zeros) to 0x00.
REQ-024 cfg_load in any state SHALL capture cfg_enable into a shadow register; WAIT_IRQ -> WR_EN SHALL occur when a load is outstanding, and the load SHALL take priority over irq.
REQ-025 WR_EN completes -> WAIT_IRQ; the outstanding-load flag SHALL clear when the write completes.
REQ-026 WAIT_IRQ -> RD_PEND when irq=1 and no load is outstanding; RD_PEND issues a read of 0x08.
REQ-027 On completion of the RD_PEND access, the FSM SHALL select the lowest set index of bus_read_data[INTR_WIDTH-1:0].
REQ-028 If that field is zero, the FSM SHALL pulse spurious for one cycle and return to WAIT_IRQ.
REQ-029 Otherwise -> DISPATCH: vec_valid=1 and vec_id=selected index, held stable until the cycle vec_valid&vec_ready.
REQ-030 DISPATCH handshake -> WR_ACK: the FSM SHALL write a one-hot of vec_id to 0x04, then return to WAIT_IRQ.
REQ-031 Each access asserts exactly one strobe with stable address/data from its first cycle until the cycle bus_access_complete=1; strobes SHALL deassert in the following cycle. Back-to-back accesses SHALL have at least one idle cycle between them.
REQ-032 bus_access_complete outside an access SHALL be ignored.
REQ-033 A per-access counter SHALL count strobe cycles; if it reaches TIMEOUT without completion, the FSM SHALL drop the strobe, set bus_error, and enter ERROR.
REQ-034 ERROR SHALL be left only by reset; in ERROR all strobes=0 and vec_valid=0.
REQ-035 Service latency: irq rising -> bus_read asserted SHALL be exactly 1 cycle when the FSM is in WAIT_IRQ.
REQ-036 irq deasserting during RD_PEND/DISPATCH/WR_ACK SHALL NOT abort the sequence.

Reset
REQ-037 Assertion of reset SHALL immediately force: state=IDLE, bus_read=0, bus_write=0, bus_address=0, bus_write_data=0, vec_valid=0, vec_id=0, spurious=0, bus_error=0, shadow mask=0, load flag=0, timeout counter=0.
REQ-038 Reset asserted mid-access SHALL abandon the access with no completion expected.

Verification
REQ-039 Reset release, responder completes in 2 cycles -> one write of 0x00000000 to 0x00, then idle in WAIT_IRQ.
REQ-040 cfg_load with cfg_enable=0xA5 while irq=1 -> write 0x000000A5 to 0x00 precedes the read of 0x08.
REQ-041 irq=1, pending read returns 0x28 -> vec_id=3, vec_valid held 4 cycles until vec_ready, then write 0x00000008 to 0x04.
REQ-042 irq=1, pending read returns 0x00 -> spurious pulses one cycle, no ack write, back to WAIT_IRQ.
REQ-043 Responder never completes a read of 0x08 -> bus_read drops after 15 cycles, bus_error=1, no further accesses until reset.
REQ-044 Reset asserted during DISPATCH -> vec_valid=0 asynchronously; sequence restarts with the enable write.
